// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for the dtcore32 data port.
// Accepts a one-cycle mem_valid_i start pulse, commits a byte-strobed write or a
// word read against internal RAM, and returns a one-cycle mem_done_o pulse
// LATENCY cycles later with the (pre-write) word on mem_rdata_o.
// Optional feature macro: DMEM_RESP_ERR_EN adds mem_err_o and access-fault checks
// (out-of-range address bits, misaligned strobed writes).
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    input  logic        mem_wen_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_strb_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        proto_err_o
`ifdef DMEM_RESP_ERR_EN
    ,
    output logic        mem_err_o
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;

    // Captured request (used when LATENCY > 1)
    logic               wen_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [3:0]         strb_q;
    logic               fault_q;

    logic [31:0]        ram [DEPTH_WORDS];

    logic               accept_c;
    logic               commit_c;
    logic [IDX_W-1:0]   idx_in_c;
    logic               fault_in_c;
    logic               c_wen_c;
    logic [IDX_W-1:0]   c_idx_c;
    logic [31:0]        c_wdata_c;
    logic [3:0]         c_strb_c;
    logic               c_fault_c;

    // A request is taken when nothing is pending, or in the completion cycle
    assign accept_c = mem_valid_i && ((state_q == S_IDLE) || mem_done_o);
    assign idx_in_c = mem_addr_i[IDX_W+1:2];

    // Access-fault classification of the incoming request
`ifdef DMEM_RESP_ERR_EN
    assign fault_in_c = (|mem_addr_i[31:IDX_W+2])
                     || (mem_wen_i && (|mem_strb_i) && (|mem_addr_i[1:0]));
`else
    logic unused_addr_c;
    assign fault_in_c    = 1'b0;
    assign unused_addr_c = ^{mem_addr_i[31:IDX_W+2], mem_addr_i[1:0]};
`endif

    // With single-cycle latency the commit uses the live request, otherwise the captured one
    assign c_wen_c   = (LATENCY == 1) ? mem_wen_i   : wen_q;
    assign c_idx_c   = (LATENCY == 1) ? idx_in_c    : idx_q;
    assign c_wdata_c = (LATENCY == 1) ? mem_wdata_i : wdata_q;
    assign c_strb_c  = (LATENCY == 1) ? mem_strb_i  : strb_q;
    assign c_fault_c = (LATENCY == 1) ? fault_in_c  : fault_q;
    assign commit_c  = (LATENCY == 1) ? accept_c
                                      : ((state_q == S_WAIT) && (cnt_q == '0));

    // Control FSM, request capture and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wen_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            fault_q     <= 1'b0;
            mem_done_o  <= 1'b0;
            mem_rdata_o <= '0;
            proto_err_o <= 1'b0;
`ifdef DMEM_RESP_ERR_EN
            mem_err_o   <= 1'b0;
`endif
        end else begin
            mem_done_o <= commit_c;
`ifdef DMEM_RESP_ERR_EN
            mem_err_o  <= commit_c && c_fault_c;
`endif
            if (commit_c) begin
                mem_rdata_o <= c_fault_c ? 32'h0 : ram[c_idx_c];
            end

            if (mem_valid_i && !accept_c) begin
                proto_err_o <= 1'b1;
            end

            if (accept_c) begin
                wen_q   <= mem_wen_i;
                idx_q   <= idx_in_c;
                wdata_q <= mem_wdata_i;
                strb_q  <= mem_strb_i;
                fault_q <= fault_in_c;
            end

            if (accept_c && (LATENCY > 1)) begin
                state_q <= S_WAIT;
                cnt_q   <= CNT_LOAD;
            end else if (commit_c) begin
                state_q <= S_IDLE;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // RAM lane writes at the completion edge; contents survive reset
    always_ff @(posedge clk_i) begin
        if (commit_c && !rst_i && c_wen_c && !c_fault_c) begin
            for (int b = 0; b < 4; b++) begin
                if (c_strb_c[b]) begin
                    ram[c_idx_c][8*b +: 8] <= c_wdata_c[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 1 and 4) driven by directed
// and random requests, checked every cycle against a transaction-level model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v     [NI];
    logic        wen   [NI];
    logic [31:0] addr  [NI];
    logic [31:0] wdata [NI];
    logic [3:0]  strb  [NI];
    logic [31:0] rdata [NI];
    logic        done  [NI];
    logic        perr  [NI];
`ifdef DMEM_RESP_ERR_EN
    logic        merr  [NI];
`endif

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_valid_i (v[0]),
        .mem_wen_i   (wen[0]),
        .mem_addr_i  (addr[0]),
        .mem_wdata_i (wdata[0]),
        .mem_strb_i  (strb[0]),
        .mem_rdata_o (rdata[0]),
        .mem_done_o  (done[0]),
        .proto_err_o (perr[0])
`ifdef DMEM_RESP_ERR_EN
        ,
        .mem_err_o   (merr[0])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_l4 (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_valid_i (v[1]),
        .mem_wen_i   (wen[1]),
        .mem_addr_i  (addr[1]),
        .mem_wdata_i (wdata[1]),
        .mem_strb_i  (strb[1]),
        .mem_rdata_o (rdata[1]),
        .mem_done_o  (done[1]),
        .proto_err_o (perr[1])
`ifdef DMEM_RESP_ERR_EN
        ,
        .mem_err_o   (merr[1])
`endif
    );

    // Reference model: memory image plus one outstanding transaction with a due cycle
    logic [31:0] ref_mem   [NI][DEPTH];
    bit          ref_known [NI][DEPTH];
    bit          pend      [NI];
    int          due       [NI];
    bit          p_wen     [NI];
    logic [31:0] p_addr    [NI];
    logic [31:0] p_wdata   [NI];
    logic [3:0]  p_strb    [NI];
    bit          e_done    [NI];
    bit          e_proto   [NI];
    bit          e_err     [NI];
    bit          e_rknown  [NI];
    logic [31:0] e_rdata   [NI];
    logic [31:0] pre       [16];

    int cyc;
    int n_total;
    int n_pass;

    function automatic int lat(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic commit(int i);
        int w;
        bit fault;
        w = int'((p_addr[i] >> 2) % DEPTH);
        fault = 1'b0;
`ifdef DMEM_RESP_ERR_EN
        fault = ((p_addr[i] >> 2) >= DEPTH)
             || (p_wen[i] && (p_strb[i] != 4'h0) && ((p_addr[i] % 4) != 0));
`endif
        e_done[i] = 1'b1;
        if (fault) begin
            e_rdata[i]  = 32'h0;
            e_rknown[i] = 1'b1;
            e_err[i]    = 1'b1;
        end else begin
            e_rdata[i]  = ref_mem[i][w];
            e_rknown[i] = ref_known[i][w];
            if (p_wen[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (p_strb[i][b]) ref_mem[i][w][8*b +: 8] = p_wdata[i][8*b +: 8];
                end
                if (p_strb[i] == 4'hF) ref_known[i][w] = 1'b1;
            end
        end
    endtask

    // Advance the model by one cycle using the inputs presented in cycle cyc
    task automatic model_cycle();
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                pend[i]     = 1'b0;
                e_done[i]   = 1'b0;
                e_err[i]    = 1'b0;
                e_proto[i]  = 1'b0;
                e_rdata[i]  = 32'h0;
                e_rknown[i] = 1'b1;
            end else begin
                if (v[i]) begin
                    if (pend[i] && (due[i] > cyc)) begin
                        e_proto[i] = 1'b1;
                    end else begin
                        pend[i]    = 1'b1;
                        due[i]     = cyc + lat(i);
                        p_wen[i]   = wen[i];
                        p_addr[i]  = addr[i];
                        p_wdata[i] = wdata[i];
                        p_strb[i]  = strb[i];
                    end
                end
                e_done[i] = 1'b0;
                e_err[i]  = 1'b0;
                if (pend[i] && (due[i] == cyc + 1)) begin
                    commit(i);
                    pend[i] = 1'b0;
                end
            end
        end
        cyc++;
    endtask

    // One clock: model, edge, sample 1 time unit later, compare, drop valid
    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("done[%0d]", i), 32'(done[i]), 32'(e_done[i]));
            chk($sformatf("proto_err[%0d]", i), 32'(perr[i]), 32'(e_proto[i]));
`ifdef DMEM_RESP_ERR_EN
            chk($sformatf("mem_err[%0d]", i), 32'(merr[i]), 32'(e_err[i]));
`endif
            if (e_rknown[i]) chk($sformatf("rdata[%0d]", i), rdata[i], e_rdata[i]);
        end
        for (int i = 0; i < NI; i++) v[i] = 1'b0;
    endtask

    task automatic req(int i, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        v[i]     = 1'b1;
        wen[i]   = w;
        addr[i]  = a;
        wdata[i] = d;
        strb[i]  = s;
    endtask

    initial begin
        logic [31:0] a;
        cyc = 0;
        n_total = 0;
        n_pass = 0;
        for (int i = 0; i < NI; i++) begin
            v[i] = 1'b0; wen[i] = 1'b0; addr[i] = '0; wdata[i] = '0; strb[i] = '0;
        end
        for (int k = 0; k < 16; k++) pre[k] = (k == 4) ? 32'h0 : $urandom;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Preload words 0..15; the LATENCY-4 instance runs back-to-back at full rate
        for (int c = 0; c < 64; c++) begin
            if (c < 16) req(0, 1'b1, 32'(c * 4), pre[c], 4'hF);
            if ((c % 4) == 0) req(1, 1'b1, 32'((c / 4) * 4), pre[c / 4], 4'hF);
            step();
        end
        chk("b2b_no_proto", 32'(perr[1]), 32'h0);

        // LATENCY 1: full write returns the old word, following read sees the new one
        req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        step();
        chk("l1_wr_done", 32'(done[0]), 32'h1);
        chk("l1_wr_old", rdata[0], 32'h0);
        req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        chk("l1_rd_done", 32'(done[0]), 32'h1);
        chk("l1_rd_new", rdata[0], 32'hDEADBEEF);

        // Partial lane write, then zero-strobe write that still completes
        req(0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100);
        step();
        req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        chk("partial_rd", rdata[0], 32'hDEAABEEF);
        req(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
        step();
        chk("strb0_done", 32'(done[0]), 32'h1);
        step();
        chk("strb0_done_low", 32'(done[0]), 32'h0);
        req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        chk("strb0_unchanged", rdata[0], 32'hDEAABEEF);

        // LATENCY 4: single done at T+4, overlapping valid at T+2 dropped and flagged
        req(1, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        chk("l4_t1_low", 32'(done[1]), 32'h0);
        step();
        chk("l4_t2_low", 32'(done[1]), 32'h0);
        req(1, 1'b0, 32'h40, 32'h0, 4'h0);
        step();
        chk("l4_t3_low", 32'(done[1]), 32'h0);
        chk("l4_t3_proto", 32'(perr[1]), 32'h1);
        step();
        chk("l4_t4_done", 32'(done[1]), 32'h1);
        chk("l4_t4_rdata", rdata[1], 32'h0);
        step();
        chk("l4_t5_low", 32'(done[1]), 32'h0);
        chk("l4_t5_proto", 32'(perr[1]), 32'h1);
        for (int k = 0; k < 6; k++) step();

        // Reset while a LATENCY-4 write is pending aborts it
        req(1, 1'b1, 32'h20, 32'h12345678, 4'hF);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_done[%0d]", i), 32'(done[i]), 32'h0);
            chk($sformatf("rst_rdata[%0d]", i), rdata[i], 32'h0);
            chk($sformatf("rst_proto[%0d]", i), 32'(perr[i]), 32'h0);
        end
        for (int k = 4; k <= 10; k++) begin
            step();
            chk("rst_no_done", 32'(done[1]), 32'h0);
        end
        req(1, 1'b0, 32'h20, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) step();
        chk("rst_word_kept_done", 32'(done[1]), 32'h1);
        chk("rst_word_kept", rdata[1], pre[8]);

        // Out-of-range address: fault when enabled, otherwise aliases onto word 0
        req(0, 1'b1, 32'h0000_1000, 32'hA5A55A5A, 4'hF);
        step();
        chk("oor_done", 32'(done[0]), 32'h1);
`ifdef DMEM_RESP_ERR_EN
        chk("oor_err", 32'(merr[0]), 32'h1);
        chk("oor_rdata_zero", rdata[0], 32'h0);
`endif
        req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
`ifdef DMEM_RESP_ERR_EN
        chk("oor_word0", rdata[0], pre[0]);
`else
        chk("alias_word0", rdata[0], 32'hA5A55A5A);
`endif

        // Random traffic with occasional high address bits, misalignment and reset
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 99) < 35) begin
                    a = 32'($urandom_range(0, 15)) << 2;
                    if ($urandom_range(0, 9) == 0) a = a | (32'h1000 << $urandom_range(0, 3));
                    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(0, 3));
                    req(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the dtcore32 data port: accepts the core's single-cycle `mem_valid` start pulse, performs a byte-strobed word write or a word read against internal RAM, and returns a one-cycle `mem_done` pulse with read data a fixed number of cycles later. It sits outside the core, alongside instruction memory, in the simulation and FPGA top levels. It also serves as the concrete memory model that bounds the done-after-valid behaviour the formal harness leaves abstract.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, 2 to 65536.
- `LATENCY`, 1: cycles from `mem_valid_i` high to `mem_done_i` high; legal range 1 to 15.

Ports:
- `clk_i`  in  1  sole clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `mem_valid_i`  in  1  request start pulse from the core; high for one cycle per request.
- `mem_wen_i`  in  1  1 = write, 0 = read; sampled with `mem_valid_i`.
- `mem_addr_i`  in  32  byte address; sampled with `mem_valid_i`.
- `mem_wdata_i`  in  32  write data, lane-aligned; sampled with `mem_valid_i`.
- `mem_strb_i`  in  4  byte-lane write enables; bit n gates `wdata[8n+7:8n]`.
- `mem_rdata_o`  out  32  read data; valid while `mem_done_o` is high, held afterward.
- `mem_done_o`  out  1  completion pulse; high for exactly one cycle per accepted request.
- `proto_err_o`  out  1  sticky flag; set when `mem_valid_i` arrives while a request is still pending.
- `mem_err_o`  out  1  access-fault flag; present only with `DMEM_RESP_ERR_EN`.

## Operation
- States:
  - IDLE: no request pending.
  - WAIT: request captured; the latency counter is running.
- Accept: in IDLE, or in the cycle `mem_done_o` is high, `mem_valid_i`=1 captures wen, addr, wdata and strb.
- Word index: `mem_addr_i[$clog2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored (aliasing), except when `DMEM_RESP_ERR_EN` is defined. `addr[1:0]` is ignored for indexing.
- Commit: the RAM access happens at the edge that raises `mem_done_o`.
  - Write: updates only the lanes whose `strb` bit is set. `strb`=0 is a legal no-op that still completes.
  - Read: `mem_rdata_o` is loaded with the full word. Strobe is ignored.
  - Write: `mem_rdata_o` is loaded with the pre-write word (read-before-write).
- Completion returns the state to IDLE unless a new request is accepted in that same cycle.
- Protocol violation: `mem_valid_i`=1 in WAIT when not in the completion cycle.
  - The new request is dropped and the pending request is unaffected.
  - `proto_err_o` is set and stays set until reset.
- Reset:
  - state IDLE, `mem_done_o`=0, `mem_rdata_o`=0, `proto_err_o`=0, `mem_err_o`=0.
  - RAM contents are not cleared.
  - A request pending when reset asserts is aborted: no write and no done.

## Timing
- Request in cycle T: `mem_done_o`=1 in cycle T+`LATENCY` only.
- `LATENCY`=1: done in the cycle immediately after valid; the WAIT state is never entered.
- `LATENCY`>1: the counter is loaded with `LATENCY`-2 on accept and decrements in WAIT. Completion is registered when the counter reaches 0.
- Back-to-back: a valid in the done cycle T+L completes at T+2L. The sustained rate is one request per L cycles.
- Write-then-read to the same word: the read accepted in the write's done cycle returns the newly written data.
- `mem_rdata_o` changes only at completion edges and at reset.

## Configuration
- Macro `DMEM_RESP_ERR_EN`, defined: `mem_err_o` exists and is fault-checked.
  - Fault conditions: any set bit of `mem_addr_i` above the index range, or `addr[1:0]`≠0 while any `strb` bit is set and `mem_wen_i`=1.
  - On a fault, completion still occurs with normal latency. `mem_err_o`=1 for that done cycle only.
  - No RAM write occurs, and `mem_rdata_o` is loaded with 32'h0.
- Macro not defined:
  - No `mem_err_o` port and no fault checks.
  - Out-of-range addresses alias, and all accesses commit.

## Test plan
- Reset, then `LATENCY`=1: write addr 0x10, data 0xDEADBEEF, strb 4'hF at T. Required: done at T+1, rdata 0x00000000 (old word). A read of 0x10 at T+1 gives done at T+2 with rdata 0xDEADBEEF.
- Partial write: word 0x10 = 0xDEADBEEF, then write data 0x00AA0000 with strb 4'b0100. A subsequent read returns 0xDEAABEEF. A write with strb 4'b0000 leaves the word unchanged and still pulses done.
- `LATENCY`=4: read at T. Required: done only at T+4, low at T+1..T+3 and at T+5. A second valid at T+2 is dropped, `proto_err_o`=1 from T+3 and held, and exactly one done occurs.
- Back-to-back, `LATENCY`=3: valid at T, T+3 and T+6. Required: done at T+3, T+6 and T+9, three pulses with no drops, `proto_err_o` stays 0.
- Reset mid-operation, `LATENCY`=5: write 0x12345678 to addr 0x20 at T, `rst_i` high at T+2. Required: no done through T+10 and word 0x20 unchanged on a later read. All outputs are 0 the cycle after reset.
- With `DMEM_RESP_ERR_EN`, `DEPTH_WORDS`=1024: write to addr 0x0000_1000 at T. Required: done at T+L with `mem_err_o`=1 and word 0 unchanged. Without the macro, the same write aliases to word 0.
